// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package ssd_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned BUF_W      = SEG_W * NUM_DIGITS;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [BUF_W-1:0]      BUF_BLANK = 28'hFFFFFFF;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    WrNone,
    WrClear,
    WrLoad,
    WrShift
  } wr_sel_e;

  function automatic logic [SEG_W-1:0] digit_sel(input logic [BUF_W-1:0] d,
                                                 input logic [IDX_W-1:0] i);
    return d[SEG_W*i +: SEG_W];
  endfunction

endpackage

// File: rtl/ssd_scan_controller_tick_gen.sv
// Free-running scan timebase: prescaler, digit slot index and blink phase.
module scan_tick_gen
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx_o,
  output logic             in_blank_o,
  output logic             blink_phase_o
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BW-1:0]    slot_q, slot_d;
  logic             phase_q, phase_d;
  logic             presc_wrap, slot_wrap;

  assign presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
  assign slot_wrap  = (slot_q == BW'(BLINK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    slot_d  = slot_q;
    phase_d = phase_q;
    if (presc_wrap) begin
      presc_d = '0;
      idx_d   = idx_q + IDX_W'(1);
      if (slot_wrap) begin
        slot_d  = '0;
        phase_d = ~phase_q;
      end else begin
        slot_d = slot_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      slot_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
    end
  end

  assign idx_o         = idx_q;
  assign in_blank_o    = (presc_q < PW'(BLANK_CYC));
  assign blink_phase_o = phase_q;

endmodule

// File: rtl/ssd_scan_controller.sv
// Four-digit segment buffer with prioritised writers, multiplexed onto shared anode/cathode pins.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_valid,
  input  logic [BUF_W-1:0]      load_seg,
  input  logic                  shift_valid,
  input  logic [SEG_W-1:0]      shift_seg,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic                  load_ack,
  output logic                  shift_ack,
  output logic [BUF_W-1:0]      digits,
  output logic [2:0]            digit_count,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [SEG_W-1:0]      seg
);

  logic [BUF_W-1:0]      digits_q, digits_d;
  logic [2:0]            count_q, count_d;
  logic                  load_ack_q, load_ack_d;
  logic                  shift_ack_q, shift_ack_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [IDX_W-1:0]      idx;
  logic                  in_blank;
  logic                  blink_phase;
  wr_sel_e               wr_sel;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .BLINK_DIV(BLINK_DIV)
  ) u_tick (
    .clk          (clk),
    .rst          (rst),
    .idx_o        (idx),
    .in_blank_o   (in_blank),
    .blink_phase_o(blink_phase)
  );

  // Fixed priority; losing requests are simply dropped.
  always_comb begin
    if (clear)            wr_sel = WrClear;
    else if (load_valid)  wr_sel = WrLoad;
    else if (shift_valid) wr_sel = WrShift;
    else                  wr_sel = WrNone;
  end

  always_comb begin
    digits_d    = digits_q;
    count_d     = count_q;
    load_ack_d  = 1'b0;
    shift_ack_d = 1'b0;
    unique case (wr_sel)
      WrClear: begin
        digits_d = BUF_BLANK;
        count_d  = 3'd0;
      end
      WrLoad: begin
        digits_d   = load_seg;
        count_d    = 3'd4;
        load_ack_d = 1'b1;
      end
      WrShift: begin
        digits_d    = {digits_q[BUF_W-SEG_W-1:0], shift_seg};
        count_d     = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
        shift_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Pins follow the current slot; blanking and blink both force the whole display dark.
  always_comb begin
    if (in_blank || (blink_phase && blink_mask[idx])) begin
      anode_d = ANODE_OFF;
      seg_d   = SEG_BLANK;
    end else begin
      anode_d = ~(NUM_DIGITS'(1) << idx);
      seg_d   = digit_sel(digits_q, idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q    <= BUF_BLANK;
      count_q     <= 3'd0;
      load_ack_q  <= 1'b0;
      shift_ack_q <= 1'b0;
      anode_q     <= ANODE_OFF;
      seg_q       <= SEG_BLANK;
    end else begin
      digits_q    <= digits_d;
      count_q     <= count_d;
      load_ack_q  <= load_ack_d;
      shift_ack_q <= shift_ack_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
    end
  end

  assign digits      = digits_q;
  assign digit_count = count_q;
  assign load_ack    = load_ack_q;
  assign shift_ack   = shift_ack_q;
  assign anode       = anode_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Randomised scoreboard bench for ssd_scan_controller with a cycle-count reference model.
module tb_ssd_scan_controller;

  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;
  localparam int unsigned BD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        load_valid = 1'b0;
  logic [27:0] load_seg = '0;
  logic        shift_valid = 1'b0;
  logic [6:0]  shift_seg = '0;
  logic [3:0]  blink_mask = '0;
  logic        load_ack, shift_ack;
  logic [27:0] digits;
  logic [2:0]  digit_count;
  logic [3:0]  anode;
  logic [6:0]  seg;

  ssd_scan_controller #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC),
    .BLINK_DIV(BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load_valid (load_valid),
    .load_seg   (load_seg),
    .shift_valid(shift_valid),
    .shift_seg  (shift_seg),
    .blink_mask (blink_mask),
    .load_ack   (load_ack),
    .shift_ack  (shift_ack),
    .digits     (digits),
    .digit_count(digit_count),
    .anode      (anode),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [27:0] dig;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          live = 0;
  int          k = 0;
  logic [27:0] mdig;
  int          mcnt;
  logic [3:0]  exp_anode;
  logic [6:0]  exp_seg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  // Model: k counts clock edges since reset; slot, digit and blink phase follow by division.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0;
        mdig = 28'hFFFFFFF;
        mcnt = 0;
        exp_anode = 4'b1111;
        exp_seg = 7'h7F;
        sb.delete();
        live = 1;
      end else if (live) begin
        int p, slot, di, ph;
        exp_t e;
        p = k % SD;
        slot = k / SD;
        di = slot % 4;
        ph = (slot / BD) % 2;
        if (p < BC || (ph == 1 && blink_mask[di])) begin
          exp_anode = 4'b1111;
          exp_seg = 7'h7F;
        end else begin
          exp_anode = 4'b1111;
          exp_anode[di] = 1'b0;
          exp_seg = mdig[7*di +: 7];
        end
        if (clear) begin
          mdig = 28'hFFFFFFF;
          mcnt = 0;
        end else if (load_valid) begin
          mdig = load_seg;
          mcnt = 4;
          e.is_load = 1; e.dig = mdig; e.cnt = 3'(mcnt);
          sb.push_back(e);
        end else if (shift_valid) begin
          mdig = {mdig[20:0], shift_seg};
          mcnt = (mcnt >= 4) ? 4 : mcnt + 1;
          e.is_load = 0; e.dig = mdig; e.cnt = 3'(mcnt);
          sb.push_back(e);
        end
        k++;
      end
    end
  end

  // Monitor: pins and buffer every cycle, acks popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        exp_t e;
        chk("anode", 32'(anode), 32'(exp_anode));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("digits", 32'(digits), 32'(mdig));
        chk("digit_count", 32'(digit_count), 32'(mcnt));
        if (load_ack || shift_ack) begin
          if (sb.size() == 0) begin
            chk("spurious_ack", 32'({load_ack, shift_ack}), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("ack_kind", 32'({load_ack, shift_ack}), e.is_load ? 32'd2 : 32'd1);
            chk("ack_digits", 32'(digits), 32'(e.dig));
            chk("ack_count", 32'(digit_count), 32'(e.cnt));
          end
        end else if (sb.size() != 0) begin
          chk("missing_ack", 32'({load_ack, shift_ack}), e.is_load ? 32'd2 : 32'd1);
          sb.delete();
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    clear = 0; load_valid = 0; shift_valid = 0; rst = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [27:0] want;
    rst = 1;
    shift_valid = 1;
    shift_seg = 7'h11;
    cyc(2);
    idle_inputs();
    cyc(20);

    // Three consecutive shifts
    shift_valid = 1; shift_seg = 7'h40; cyc();
    shift_seg = 7'h79; cyc();
    shift_seg = 7'h24; cyc();
    idle_inputs();
    want = {7'h7F, 7'h40, 7'h79, 7'h24};
    chk("three_shift_digits", 32'(digits), 32'(want));
    chk("three_shift_count", 32'(digit_count), 32'd3);
    cyc(18);

    // Load beats shift
    load_valid = 1; load_seg = 28'h0000000; shift_valid = 1; shift_seg = 7'h55;
    cyc();
    idle_inputs();
    chk("load_win_ack", 32'({load_ack, shift_ack}), 32'd2);
    chk("load_win_count", 32'(digit_count), 32'd4);
    cyc(3);

    // Clear beats load, then five shifts saturate the count
    clear = 1; load_valid = 1; load_seg = 28'h1234567;
    cyc();
    idle_inputs();
    chk("clear_digits", 32'(digits), 32'h0FFFFFFF);
    chk("clear_acks", 32'({load_ack, shift_ack}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      shift_valid = 1;
      shift_seg = 7'($urandom);
      cyc();
    end
    idle_inputs();
    chk("saturated_count", 32'(digit_count), 32'd4);
    cyc(4);

    // Blink digit 0 across several phases
    blink_mask = 4'b0001;
    cyc(40);
    blink_mask = 4'b0000;

    // Randomised traffic including occasional resets and mask changes
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rst = (r == 99);
      clear = (r < 3);
      load_valid = ($urandom_range(0, 9) < 2);
      shift_valid = ($urandom_range(0, 9) < 5);
      load_seg = 28'($urandom);
      shift_seg = 7'($urandom);
      if (i % 50 == 0) blink_mask = 4'($urandom);
      cyc();
    end
    idle_inputs();
    blink_mask = 4'b0000;

    // Reset mid-slot with a shift pending
    load_valid = 1; load_seg = 28'h2AAAAAA; cyc();
    idle_inputs();
    cyc(6);
    rst = 1; shift_valid = 1; shift_seg = 7'h00;
    cyc();
    idle_inputs();
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_shift_ack", 32'(shift_ack), 32'd0);
    chk("rst_digits", 32'(digits), 32'h0FFFFFFF);
    chk("rst_count", 32'(digit_count), 32'd0);
    cyc(20);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
